// File: rtl/truth_table_sweeper.sv
// Sweeps every NUM_W-bit code into a combinational comparator and captures one
// sum-of-minterms mask per comparator output bit.
module truth_table_sweeper #(
    parameter int NUM_W         = 4,
    parameter int OUT_W         = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [OUT_W-1:0]            cmp_out,
    output logic [NUM_W-1:0]            num,
    output logic                        busy,
    output logic                        done,
    output logic                        valid,
    output logic [OUT_W*(2**NUM_W)-1:0] minterms
);

    localparam int CODES = 2 ** NUM_W;
    localparam int MW    = OUT_W * CODES;
    localparam int IDX_W = $clog2(MW);

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [NUM_W-1:0] LAST_CODE   = {NUM_W{1'b1}};

    // Handshake: start is a level request sampled on each rising edge; it is
    // accepted only in IDLE, and done marks the single cycle the result lands.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [3:0]       cnt, cnt_d;
    logic [NUM_W-1:0] num_d;
    logic             busy_d, done_d, valid_d;
    logic [MW-1:0]    minterms_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            num      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            minterms <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            num      <= num_d;
            busy     <= busy_d;
            done     <= done_d;
            valid    <= valid_d;
            minterms <= minterms_d;
        end
    end

    // Outputs are registered with the values belonging to the state being entered.
    always_comb begin : next_logic
        logic [IDX_W-1:0] idx;
        state_d    = state;
        cnt_d      = cnt;
        num_d      = num;
        busy_d     = busy;
        done_d     = 1'b0;
        valid_d    = valid;
        minterms_d = minterms;
        idx        = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    minterms_d = '0;
                    valid_d    = 1'b0;
                    num_d      = '0;
                    busy_d     = 1'b1;
                    cnt_d      = SETTLE_LOAD;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                for (int k = 0; k < OUT_W; k++) begin
                    idx             = IDX_W'(k * CODES) + IDX_W'(num);
                    minterms_d[idx] = cmp_out[k];
                end
                // Terminal check precedes the increment so num never wraps here.
                if (num == LAST_CODE) begin
                    num_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    num_d   = num + 1'b1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: an edge-count model of the sweep timeline is
// compared against two DUT instances (SETTLE_CYCLES = 1 and 3) every cycle.
module tb_truth_table_sweeper;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic [2:0]  cmp_a, cmp_b;
    logic [3:0]  num_a, num_b;
    logic        busy_a, busy_b, done_a, done_b, valid_a, valid_b;
    logic [47:0] mt_a, mt_b;

    int          n_checks;
    int          n_pass;
    int          mode;
    logic [2:0]  rand_tab [16];
    logic [2:0]  d1, d2;

    // Model state: edges elapsed since the accepting edge, -1 when idle.
    int          m_e     [2];
    logic        m_valid [2];
    logic [47:0] m_mask  [2];

    truth_table_sweeper dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .cmp_out(cmp_a),
        .num(num_a), .busy(busy_a), .done(done_a), .valid(valid_a), .minterms(mt_a)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .cmp_out(cmp_b),
        .num(num_b), .busy(busy_b), .done(done_b), .valid(valid_b), .minterms(mt_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit inequality comparator on the two 2-bit halves: {gt, ne, lt}.
    function automatic logic [2:0] cmp_fn(input logic [3:0] v);
        logic [1:0] a, b;
        a = v[3:2];
        b = v[1:0];
        return {a > b, a != b, a < b};
    endfunction

    always_comb begin
        if (mode == 1)      cmp_a = cmp_fn(num_a);
        else if (mode == 2) cmp_a = rand_tab[num_a];
        else                cmp_a = num_a[2:0];
    end

    // Slow comparator stub: num[2:0] through two registers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 <= '0;
            d2 <= '0;
        end else begin
            d1 <= num_b[2:0];
            d2 <= d1;
        end
    end
    assign cmp_b = d2;

    // ---------------- reference model ----------------
    function automatic int s1_of(input int i);
        return (i == 1) ? 4 : 2;
    endfunction

    function automatic logic [2:0] exp_code(input int i, input int n);
        logic [3:0] v;
        v = 4'(n);
        if (i == 1)    return v[2:0];
        if (mode == 1) return cmp_fn(v);
        if (mode == 2) return rand_tab[n];
        return v[2:0];
    endfunction

    task automatic model_step(input int i, input logic st);
        int         s1;
        int         tot;
        int         n;
        logic [2:0] e;
        s1  = s1_of(i);
        tot = 16 * s1;
        if (m_e[i] < 0) begin
            if (st) begin
                m_e[i]     = 0;
                m_valid[i] = 1'b0;
                m_mask[i]  = '0;
            end
        end else if (m_e[i] == tot) begin
            m_e[i] = -1;
        end else begin
            m_e[i] = m_e[i] + 1;
            if (m_e[i] % s1 == 0) begin
                n = m_e[i] / s1 - 1;
                e = exp_code(i, n);
                for (int k = 0; k < 3; k++) m_mask[i][k*16 + n] = e[k];
            end
            if (m_e[i] == tot) m_valid[i] = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_e[i]     = -1;
                m_valid[i] = 1'b0;
                m_mask[i]  = '0;
            end
        end else begin
            model_step(0, start_a);
            model_step(1, start_b);
        end
    end

    function automatic int exp_num(input int i);
        int tot;
        tot = 16 * s1_of(i);
        return (m_e[i] >= 0 && m_e[i] < tot) ? m_e[i] / s1_of(i) : 0;
    endfunction

    function automatic logic exp_busy(input int i);
        return (m_e[i] >= 0 && m_e[i] < 16 * s1_of(i));
    endfunction

    function automatic logic exp_done(input int i);
        return (m_e[i] == 16 * s1_of(i));
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_all();
        chk("a.num",      64'(num_a),   64'(exp_num(0)));
        chk("a.busy",     64'(busy_a),  64'(exp_busy(0)));
        chk("a.done",     64'(done_a),  64'(exp_done(0)));
        chk("a.valid",    64'(valid_a), 64'(m_valid[0]));
        chk("a.minterms", 64'(mt_a),    64'(m_mask[0]));
        chk("b.num",      64'(num_b),   64'(exp_num(1)));
        chk("b.busy",     64'(busy_b),  64'(exp_busy(1)));
        chk("b.done",     64'(done_b),  64'(exp_done(1)));
        chk("b.valid",    64'(valid_b), 64'(m_valid[1]));
        chk("b.minterms", 64'(mt_b),    64'(m_mask[1]));
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic dn(input int inst);
        return (inst == 1) ? done_b : done_a;
    endfunction

    task automatic sweep(input int inst, input int poke, output int lat, output int extra);
        logic poked;
        poked = 1'b0;
        @(negedge clk);
        if (inst == 1) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        lat = 1;
        while (!dn(inst) && lat < 300) begin
            @(negedge clk);
            lat++;
            if (inst == 0) begin
                if (start_a) start_a = 1'b0;
                else if (!poked && poke >= 0 && int'(num_a) == poke) begin
                    start_a = 1'b1;
                    poked   = 1'b1;
                end
            end
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (dn(inst)) extra++;
        end
    endtask

    task automatic check_stub_masks(input string tag, input logic [47:0] m);
        chk({tag, ".mask0"}, 64'(m[15:0]),  64'h0000_AAAA);
        chk({tag, ".mask1"}, 64'(m[31:16]), 64'h0000_CCCC);
        chk({tag, ".mask2"}, 64'(m[47:32]), 64'h0000_F0F0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, extra, dcnt, t;
        n_checks = 0;
        n_pass   = 0;
        mode     = 0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        rst_n    = 1'b0;
        for (int n = 0; n < 16; n++) rand_tab[n] = 3'($urandom_range(0, 7));

        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset.num",      64'(num_a),   64'd0);
        chk("reset.busy",     64'(busy_a),  64'd0);
        chk("reset.valid",    64'(valid_a), 64'd0);
        chk("reset.minterms", 64'(mt_a),    64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // stub sweep, cmp_out = num[2:0]
        sweep(0, -1, lat, extra);
        chk("stub.latency", 64'(lat), 64'd33);
        chk("stub.extra_done", 64'(extra), 64'd0);
        check_stub_masks("stub", mt_a);
        chk("stub.valid", 64'(valid_a), 64'd1);

        // start pulsed mid-sweep at num = 5 is ignored
        sweep(0, 5, lat, extra);
        chk("ignored.latency", 64'(lat), 64'd33);
        chk("ignored.extra_done", 64'(extra), 64'd0);
        check_stub_masks("ignored", mt_a);

        // real comparator
        mode = 1;
        sweep(0, -1, lat, extra);
        chk("cmp.latency", 64'(lat), 64'd33);
        chk("cmp.bit46", 64'(mt_a[46]), 64'd1);
        chk("cmp.bit30", 64'(mt_a[30]), 64'd1);
        chk("cmp.bit14", 64'(mt_a[14]), 64'd0);
        for (int n = 0; n < 16; n++)
            chk("cmp.code", 64'({mt_a[32+n], mt_a[16+n], mt_a[n]}), 64'(cmp_fn(4'(n))));

        // random truth table
        mode = 2;
        sweep(0, -1, lat, extra);
        for (int n = 0; n < 16; n++)
            chk("rand.code", 64'({mt_a[32+n], mt_a[16+n], mt_a[n]}), 64'(rand_tab[n]));

        // start held high: back-to-back sweeps with one idle cycle between
        mode    = 0;
        dcnt    = 0;
        @(negedge clk);
        start_a = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (done_a) dcnt++;
            if (i == 40) start_a = 1'b0;
        end
        chk("b2b.done_count", 64'(dcnt), 64'd2);
        check_stub_masks("b2b", mt_a);

        // slow comparator with SETTLE_CYCLES = 3
        sweep(1, -1, lat, extra);
        chk("delay.latency", 64'(lat), 64'd65);
        chk("delay.extra_done", 64'(extra), 64'd0);
        check_stub_masks("delay", mt_b);
        chk("delay.valid", 64'(valid_b), 64'd1);

        // asynchronous abort at num = 7, then a fresh sweep
        mode = 2;
        for (int n = 0; n < 16; n++) rand_tab[n] = 3'($urandom_range(0, 7));
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        t = 0;
        while (num_a != 4'd7 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("abort.reached_7", 64'(t < 100), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.num",      64'(num_a),   64'd0);
        chk("abort.busy",     64'(busy_a),  64'd0);
        chk("abort.done",     64'(done_a),  64'd0);
        chk("abort.valid",    64'(valid_a), 64'd0);
        chk("abort.minterms", 64'(mt_a),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart.valid_low", 64'(valid_a), 64'd0);
        sweep(0, -1, lat, extra);
        chk("restart.latency", 64'(lat), 64'd33);
        chk("restart.valid", 64'(valid_a), 64'd1);
        for (int n = 0; n < 16; n++)
            chk("restart.code", 64'({mt_a[32+n], mt_a[16+n], mt_a[n]}), 64'(rand_tab[n]));

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus-and-capture stage that sits directly upstream of the 4-bit combinational inequality comparator.
- Drives the comparator's NUM input through every code from 0 to 2^NUM_W-1.
- Samples the comparator's OUT bus for each code and assembles one truth-table (minterm) mask per output bit.
- The masks give the canonical sum-of-minterms form of each comparator output, for standard-form checking downstream.

Parameters:
- NUM_W, 4, width of the driven number bus. The number of codes swept is 2^NUM_W.
- OUT_W, 3, width of the comparator output bus being captured.
- SETTLE_CYCLES, 1, wait cycles between driving a new code and sampling cmp_out. Legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a sweep. Honoured only in IDLE.
- cmp_out  input  OUT_W  comparator result for the current num.
- num  output  NUM_W  code driven to the comparator input.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- valid  output  1  minterms hold a complete sweep result.
- minterms  output  OUT_W*2^NUM_W  bit [k*2^NUM_W + n] = cmp_out[k] sampled while num == n.

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low.
  - While rst_n = 0: state = IDLE, num = 0, busy = 0, done = 0, valid = 0, minterms = 0, settle counter = 0.
  - Reset applied mid-sweep aborts the sweep immediately, with no partial result retained.
- States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
- IDLE:
  - On start = 1: clear minterms to 0, valid <= 0, num <= 0, busy <= 1, load counter = SETTLE_CYCLES, go to SETTLE.
  - start = 0: remain in IDLE and hold all outputs.
- SETTLE:
  - Decrement the counter each cycle; num is held constant.
  - When the counter reaches 1, go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE, one cycle:
  - On the closing edge, write cmp_out[k] into minterms[k*2^NUM_W + num] for every k; all other bits are unchanged.
  - If num == 2^NUM_W-1: go to DONE.
  - Otherwise: num <= num+1, reload the counter, go to SETTLE.
- DONE, one cycle:
  - done = 1, valid <= 1, busy <= 0, num <= 0, go to IDLE.
  - done is 0 in every other state.
- Latency:
  - Each code occupies SETTLE_CYCLES+1 cycles.
  - done is asserted on cycle 1 + 2^NUM_W*(SETTLE_CYCLES+1) after the edge that accepted start. This is 33 cycles at the defaults.
  - A comparator with up to SETTLE_CYCLES cycles of registered latency is captured correctly.
- start handling:
  - start while busy = 1, including in the SETTLE, SAMPLE or DONE states, is ignored. There is no queueing and no restart.
  - start held high continuously produces back-to-back sweeps with one IDLE cycle between them.
- Output stability:
  - minterms and valid remain stable in IDLE until the next accepted start.
  - num wraps only via the DONE state and never counts past 2^NUM_W-1.
- Widths: all arithmetic is unsigned. num increments without overflow because the terminal value is checked before incrementing.

Test Plan:
- Reset: assert rst_n = 0 asynchronously between clock edges, including mid-sweep at num = 7 -> num, busy, done, valid and minterms go to 0 immediately with no clock edge required.
- Stub sweep, defaults:
  - Stimulus: cmp_out = num[2:0] combinationally, pulse start.
  - Required: busy high for 32 cycles, done pulses at cycle 33.
  - Required masks: minterms[15:0] = 0xAAAA, minterms[31:16] = 0xCCCC, minterms[47:32] = 0xF0F0, valid = 1.
- Comparator sweep:
  - Stimulus: sweep the real 4-bit inequality comparator.
  - Required at code 14: minterms[46] = 1, minterms[30] = 1, minterms[14] = 0, i.e. OUT = 3'b110.
  - Required: every mask bit matches a direct combinational evaluation of the comparator at the same code.
- Ignored start:
  - Stimulus: pulse start again at num = 5 during a sweep.
  - Required: num continues 6, 7, ...; done occurs exactly once at cycle 33; the result is identical to a clean sweep.
- Delayed comparator:
  - Stimulus: SETTLE_CYCLES = 3, stub cmp_out = num[2:0] delayed by 2 registers.
  - Required: masks 0xAAAA, 0xCCCC, 0xF0F0; done at cycle 65.
- Restart after reset:
  - Stimulus: abort a sweep with reset, then issue a fresh start.
  - Required: valid stays 0 until the new done; the final masks are complete and correct.
